// File: rtl/pc_fetch_seq_if.sv
// Instruction-memory request channel: fetch sequencer presents a request
// (valid + address), instruction memory answers with ready.
interface pc_fetch_seq_if;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;

  modport master (
    output imem_valid,
    output imem_addr,
    input  imem_ready
  );

  modport slave (
    input  imem_valid,
    input  imem_addr,
    output imem_ready
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch-PC sequencer: owns the fetch PC, issues instruction-memory requests,
// steps by 4, applies EX redirects and traps misaligned redirect targets.
//
// state | meaning
// BOOT  | just out of reset, no request presented yet
// RUN   | request presented (imem_valid=1), waiting for or taking accepts
// STALL | no request presented, waiting for stall to drop
// TRAP  | misaligned redirect seen last edge; next edge loads TRAP_VECTOR
module pc_fetch_seq #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  pc_fetch_seq_if.master        imem,
  output logic [31:0]           pc_out,
  output logic                  pc_valid,
  output logic                  trap,
  output logic [31:0]           trap_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_out_d;
  logic        pc_valid_d;
  logic        trap_d;
  logic [31:0] trap_addr_d;
  logic        accept;

  assign accept          = valid_q & imem.imem_ready;
  assign imem.imem_valid = valid_q;
  assign imem.imem_addr  = addr_q;

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      valid_q   <= 1'b0;
      addr_q    <= RESET_VECTOR;
      pc_out    <= 32'h0;
      pc_valid  <= 1'b0;
      trap      <= 1'b0;
      trap_addr <= 32'h0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      pc_out    <= pc_out_d;
      pc_valid  <= pc_valid_d;
      trap      <= trap_d;
      trap_addr <= trap_addr_d;
    end
  end

  // Next state: trap exit beats redirect, redirect beats accept, else hold.
  // A presented but unaccepted request is never withdrawn by stall.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    pc_out_d    = pc_out;
    pc_valid_d  = 1'b0;
    trap_d      = 1'b0;
    trap_addr_d = trap_addr;

    if (state_q == TRAP) begin
      addr_d  = TRAP_VECTOR;
      valid_d = !stall;
      state_d = stall ? STALL : RUN;
    end else if (redirect) begin
      // Any same-cycle accept is squashed: pc_valid stays low.
      if (redirect_pc[1:0] == 2'b00) begin
        addr_d  = redirect_pc;
        valid_d = !stall;
        state_d = stall ? STALL : RUN;
      end else begin
        valid_d     = 1'b0;
        trap_d      = 1'b1;
        trap_addr_d = redirect_pc;
        state_d     = TRAP;
      end
    end else if (accept) begin
      pc_out_d   = addr_q;
      pc_valid_d = 1'b1;
      addr_d     = addr_q + 32'd4;
      valid_d    = !stall;
      state_d    = stall ? STALL : RUN;
    end else if (!valid_q) begin
      // BOOT and STALL: present the current address once stall drops.
      if (!stall) begin
        valid_d = 1'b1;
        state_d = RUN;
      end else begin
        state_d = STALL;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: directed scenarios followed by
// random stimulus, all compared each cycle against a behavioural model.
module tb_pc_fetch_seq;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        trap;
  logic [31:0] trap_addr;

  pc_fetch_seq_if imem ();

  pc_fetch_seq #(
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .pc_out      (pc_out),
    .pc_valid    (pc_valid),
    .trap        (trap),
    .trap_addr   (trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors    = 0;
  int n_miscompare = 0;

  // reference model: what the sequencer should be showing right now
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_pc_out;
  logic        m_pc_valid;
  logic        m_trap;
  logic [31:0] m_trap_addr;
  bit          m_trap_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid        = 1'b0;
    m_addr         = RESET_VECTOR;
    m_pc_out       = 32'h0;
    m_pc_valid     = 1'b0;
    m_trap         = 1'b0;
    m_trap_addr    = 32'h0;
    m_trap_pending = 1'b0;
  endtask

  // one rising edge worth of the fetch rules
  task automatic model_step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    bit acc;
    acc        = m_valid && rdy;
    m_pc_valid = 1'b0;
    m_trap     = 1'b0;
    if (m_trap_pending) begin
      m_trap_pending = 1'b0;
      m_addr         = TRAP_VECTOR;
      m_valid        = !s;
    end else if (r) begin
      if (rpc % 4 == 0) begin
        m_addr  = rpc;
        m_valid = !s;
      end else begin
        m_trap_pending = 1'b1;
        m_valid        = 1'b0;
        m_trap         = 1'b1;
        m_trap_addr    = rpc;
      end
    end else if (acc) begin
      m_pc_out   = m_addr;
      m_pc_valid = 1'b1;
      m_addr     = m_addr + 32'd4;
      m_valid    = !s;
    end else if (!m_valid && !s) begin
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("imem_valid", {31'b0, imem.imem_valid}, {31'b0, m_valid});
    chk("imem_addr",  imem.imem_addr, m_addr);
    chk("pc_out",     pc_out, m_pc_out);
    chk("pc_valid",   {31'b0, pc_valid}, {31'b0, m_pc_valid});
    chk("trap",       {31'b0, trap}, {31'b0, m_trap});
    chk("trap_addr",  trap_addr, m_trap_addr);
  endtask

  // called at a falling edge: drive, let one rising edge pass, check
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    stall           = s;
    redirect        = r;
    redirect_pc     = rpc;
    imem.imem_ready = rdy;
    model_step(s, r, rpc, rdy);
    @(negedge clk);
    check_all();
  endtask

  // asserts reset shortly after a rising edge, checks the immediate effect,
  // releases it at the next falling edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    logic        s, r, rdy;
    logic [31:0] rpc;
    int          sel;

    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // sequential fetch 0x0 .. 0xC, then 0x10 held with ready low and stall pulsed
    repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    // redirect squashing an accept of 0x14
    cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    // misaligned redirect, then a redirect ignored while in TRAP
    cyc(1'b0, 1'b1, 32'h0000_0202, 1'b1);
    cyc(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    // wraparound with stall on the accept
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    // reset while a request at 0x40 is outstanding
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    // boot with stall held
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      rpc = $urandom;
      if (sel < 5)       rpc[1:0] = 2'b00;
      else if (sel < 7)  rpc[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 7) rpc = 32'hFFFF_FFF8;
      else if (sel == 8) rpc = 32'hFFFF_FFFC;
      if (i % 400 == 399) do_reset();
      else cyc(s, r, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

Fetch-PC sequencer for the 5-stage core. It owns the architectural fetch PC and issues instruction-memory requests over a valid/ready handshake. It advances sequentially by 4 and applies branch/jump redirects from EX. It also reports each accepted fetch address to the IF/ID register and traps misaligned redirect targets to a fixed vector.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, fetch address after a misaligned-redirect trap
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hazard-unit request to stop launching new fetches
- redirect  input  1  EX-stage taken branch/jump, single-cycle pulse
- redirect_pc  input  32  redirect target, valid when redirect=1
- imem_ready  input  1  instruction memory accepts request this cycle
- imem_valid  output  1  request valid (registered)
- imem_addr  output  32  request address = fetch PC (registered)
- pc_out  output  32  address of most recently accepted fetch, to IF/ID
- pc_valid  output  1  one-cycle pulse: pc_out updated by a non-squashed accept
- trap  output  1  one-cycle pulse: misaligned redirect detected
- trap_addr  output  32  offending redirect target, held until next trap

## Operation
- States: BOOT, RUN, STALL, TRAP.
- Accept = imem_valid & imem_ready.
- Priority each cycle, high to low: TRAP-state handling, redirect, accept, hold.
- BOOT: entered on reset. First clock with rst=1 goes to RUN with imem_valid<=1 if stall=0, else to STALL.
- Redirect, redirect_pc[1:0]==0:
  - imem_addr<=redirect_pc, imem_valid<=!stall, state RUN or STALL.
  - Any accept in the same cycle is squashed: pc_valid<=0.
  - An outstanding unaccepted request is abandoned. Instruction memory is a side-effect-free lookup.
- Redirect, redirect_pc[1:0]!=0:
  - State TRAP, imem_valid<=0, trap<=1, trap_addr<=redirect_pc.
  - Same-cycle accept is squashed.
- TRAP, one cycle only:
  - imem_addr<=TRAP_VECTOR, imem_valid<=!stall, state RUN or STALL.
  - redirect is ignored in this cycle.
- Accept without redirect:
  - pc_out<=imem_addr, pc_valid<=1, imem_addr<=imem_addr+4.
  - imem_valid<=!stall; state RUN if stall=0, else STALL.
- imem_valid=1 and imem_ready=0: imem_addr and imem_valid hold regardless of stall. Stall never retracts a presented request.
- STALL (imem_valid=0): when stall=0, imem_valid<=1 and state RUN; the address is unchanged.
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
- Alignment: only bits [1:0] are checked. imem_addr[1:0] is always 0.

## Timing
- Reset (async, rst=0) sets:
  - state=BOOT, imem_valid=0, imem_addr=RESET_VECTOR
  - pc_out=0, pc_valid=0, trap=0, trap_addr=0
- Reset asserted mid-request drops the request immediately, with no handshake completion.
- First imem_valid=1 appears one clock after rst deasserts, with stall=0.
- Sequential throughput: one fetch per cycle while imem_ready=1 and stall=0.
- pc_valid/pc_out follow the accepting edge by 0 cycles: they are registered on that edge and visible the next cycle.
- Redirect latency: redirect at edge t gives imem_addr=target, imem_valid=1 after edge t.
- Trap latency: trap pulses after edge t. TRAP_VECTOR is presented after edge t+1.
- stall is sampled only on accept, redirect, TRAP exit and STALL; it has no combinational path to outputs.
- All outputs are registered.

## Test plan
- Reset release, stall=0, imem_ready=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; pc_valid=1 with pc_out 0x0, 0x4 one cycle later.
- imem_ready=0 for 3 cycles at addr 0x10, stall pulsed meanwhile -> imem_valid stays 1, imem_addr stays 0x10, no pc_valid; first ready cycle accepts 0x10.
- redirect=1, redirect_pc=0x200 in the same cycle as an accept of 0x14 -> pc_valid=0 (squash); next cycle imem_addr=0x200, imem_valid=1.
- redirect_pc=0x202 -> trap=1 one cycle, trap_addr=0x202, imem_valid=0; next cycle imem_addr=0x100, imem_valid=1; a redirect during TRAP is ignored.
- Accept at 0xFFFF_FFFC -> next imem_addr=0x0000_0000; stall=1 on that accept -> imem_valid=0 until stall falls, then 0x0 is presented.
- rst asserted while imem_valid=1 at 0x40 -> all outputs return to reset values immediately; after release, fetch restarts at RESET_VECTOR.
